// File: rtl/timer_capture.sv
// timer_capture: free-running timebase with synchronized edge capture into a timestamp FIFO.
// Optional glitch filter on the synchronized input is enabled by defining TIMER_CAPTURE_FILTER_EN.
module timer_capture #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cap_en,
  input  logic [1:0]             i_cap_edge_sel,
  input  logic                   i_cap_clr_on_cap,
  input  logic                   i_cap_sig,
  input  logic                   i_cap_ready,
  input  logic                   i_ovr_clr,
  output logic [CNT_W-1:0]       o_cap_value,
  output logic                   o_cap_valid,
  output logic [$clog2(DEPTH):0] o_cap_level,
  output logic                   o_cap_overrun,
  output logic [CNT_W-1:0]       o_cnt_value
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [1:0] SEL_RISE = 2'b00;
  localparam logic [1:0] SEL_FALL = 2'b01;
  localparam logic [1:0] SEL_BOTH = 2'b10;

  logic             sync1_q, sync2_q, hist_q;
  logic             sig_lvl;
  logic             rise, fall, edge_hit;
  logic [2:0]       arm_q, arm_d;
  logic             armed;
  logic             cap_evt_q, cap_evt_d;

  logic             push, pop, push_ok, full;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovr_q, ovr_d;

`ifdef TIMER_CAPTURE_FILTER_EN
  // Level follows the synchronized input only once three consecutive samples agree.
  localparam logic [2:0] ARM_CYC = 3'd5;

  logic samp_a_q, samp_b_q;

  always_comb begin
    sig_lvl = hist_q;
    if ((sync2_q == samp_a_q) && (samp_a_q == samp_b_q)) begin
      sig_lvl = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a_q <= 1'b0;
      samp_b_q <= 1'b0;
    end else begin
      samp_a_q <= sync2_q;
      samp_b_q <= samp_a_q;
    end
  end
`else
  localparam logic [2:0] ARM_CYC = 3'd3;

  assign sig_lvl = sync2_q;
`endif

  // Edges are masked until the input path has refilled after reset, so a level
  // held through reset is not mistaken for a fresh transition.
  always_comb begin
    rise     = sig_lvl & ~hist_q;
    fall     = ~sig_lvl & hist_q;
    edge_hit = 1'b0;
    case (i_cap_edge_sel)
      SEL_RISE: edge_hit = rise;
      SEL_FALL: edge_hit = fall;
      SEL_BOTH: edge_hit = rise | fall;
      default:  edge_hit = 1'b0;
    endcase
    armed     = (arm_q == ARM_CYC);
    arm_d     = armed ? arm_q : arm_q + 3'd1;
    cap_evt_d = edge_hit & armed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      arm_q     <= 3'd0;
      cap_evt_q <= 1'b0;
    end else begin
      sync1_q   <= i_cap_sig;
      sync2_q   <= sync1_q;
      hist_q    <= sig_lvl;
      arm_q     <= arm_d;
      cap_evt_q <= cap_evt_d;
    end
  end

  // A capture into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    push     = cap_evt_q & i_cap_en;
    pop      = (level_q != '0) & i_cap_ready;
    push_ok  = push & (~full | pop);

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end

    ovr_d = ovr_q;
    if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (push && !push_ok) begin
      ovr_d = 1'b1;
    end

    if (!i_cap_en) begin
      cnt_d = '0;
    end else if (push && i_cap_clr_on_cap) begin
      cnt_d = CNT_W'(1);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= cnt_q;
    end
  end

  assign o_cap_valid   = (level_q != '0);
  assign o_cap_value   = o_cap_valid ? mem_q[rd_ptr_q] : '0;
  assign o_cap_level   = level_q;
  assign o_cap_overrun = ovr_q;
  assign o_cnt_value   = cnt_q;

endmodule
